mdio_arb_seq: RTL and testbench

MDIO_ARB_SEQ -- requirements
Module: mdio_arb_seq

---
 rtl/mdio_arb_seq_if.sv | 32 +++
 rtl/mdio_arb_seq.sv | 145 ++++++++++++++
 tb/tb_mdio_arb_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_arb_seq_if.sv
// Host / MDIO-controller / link-status signal bundle for mdio_arb_seq.
// The slave modport is the arbiter; the master modport is the side that
// issues host requests and plays the MDIO controller.
interface mdio_arb_seq_if;
    // host request channel
    logic        host_req;
    logic [31:0] host_wr_data;
    logic        host_done;
    logic [31:0] host_rd_data;
    logic        host_err;
    // MDIO controller channel
    logic        mdio_en;
    logic [31:0] mdio_wr_data;
    logic        mdio_done;
    logic [31:0] mdio_rd_data;
    // autonomous link poll results
    logic        link_up;
    logic [15:0] link_status;
    logic        poll_err;

    modport slave (
        input  host_req, host_wr_data, mdio_done, mdio_rd_data,
        output host_done, host_rd_data, host_err, mdio_en, mdio_wr_data,
               link_up, link_status, poll_err
    );

    modport master (
        output host_req, host_wr_data, mdio_done, mdio_rd_data,
        input  host_done, host_rd_data, host_err, mdio_en, mdio_wr_data,
               link_up, link_status, poll_err
    );
endinterface

// File: rtl/mdio_arb_seq.sv
// Arbitrates one MDIO controller between host-issued frames and a
// periodic BMSR status poll, with a per-transaction completion timeout.
module mdio_arb_seq #(
    parameter logic [4:0]  C_PHY_ADDR    = 5'd1,
    parameter int unsigned C_POLL_CYCLES = 1000000,
    parameter int unsigned C_TIMEOUT     = 4096
) (
    input  logic           s_axi_aclk,
    input  logic           s_axi_aresetn,
    mdio_arb_seq_if.slave  bus
);

    localparam logic [23:0] POLL_LAST  = 24'(C_POLL_CYCLES - 1);
    localparam logic [15:0] TO_LAST    = 16'(C_TIMEOUT - 1);
    // read of register 1 (BMSR) at the poll PHY address
    localparam logic [31:0] POLL_FRAME = {2'b01, 2'b10, C_PHY_ADDR, 5'd1, 2'b10, 16'h0000};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_POLL, OWN_HOST} owner_t;

    state_t      state;
    owner_t      owner;
    owner_t      last_grant;
    logic [23:0] poll_timer;
    logic        poll_pend;
    logic        poll_wrap;
    logic [15:0] to_cnt;
    logic        poll_grant;
    logic        host_grant;

    logic        mdio_en;
    logic [31:0] mdio_wr_data;
    logic        host_done;
    logic [31:0] host_rd_data;
    logic        host_err;
    logic        link_up;
    logic [15:0] link_status;
    logic        poll_err;

    assign poll_wrap = (poll_timer == POLL_LAST);

    // Grant decision in IDLE: host wins unless it was served last and a poll is owed.
    always_comb begin
        poll_grant = 1'b0;
        host_grant = 1'b0;
        if (state == IDLE) begin
            poll_grant = poll_pend && (!bus.host_req || last_grant == OWN_HOST);
            host_grant = bus.host_req && !poll_grant;
        end
    end

    // Free-running poll interval timer; a wrap while a poll is already owed is absorbed.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            poll_timer <= '0;
            poll_pend  <= 1'b0;
        end else begin
            poll_timer <= poll_wrap ? '0 : poll_timer + 1'b1;
            if (poll_grant)
                poll_pend <= 1'b0;
            else if (poll_wrap)
                poll_pend <= 1'b1;
        end
    end

    // Transaction sequencer with registered outputs: grant, one-cycle issue, wait for done or timeout.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state        <= IDLE;
            owner        <= OWN_POLL;
            last_grant   <= OWN_POLL;
            to_cnt       <= '0;
            mdio_en      <= 1'b0;
            mdio_wr_data <= '0;
            host_done    <= 1'b0;
            host_rd_data <= '0;
            host_err     <= 1'b0;
            link_up      <= 1'b0;
            link_status  <= '0;
            poll_err     <= 1'b0;
        end else begin
            mdio_en   <= 1'b0;
            host_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_grant) begin
                        state        <= ISSUE;
                        mdio_en      <= 1'b1;
                        mdio_wr_data <= POLL_FRAME;
                        owner        <= OWN_POLL;
                        last_grant   <= OWN_POLL;
                        to_cnt       <= '0;
                    end else if (host_grant) begin
                        state        <= ISSUE;
                        mdio_en      <= 1'b1;
                        mdio_wr_data <= bus.host_wr_data;
                        owner        <= OWN_HOST;
                        last_grant   <= OWN_HOST;
                        host_err     <= 1'b0;
                        to_cnt       <= '0;
                    end
                end
                ISSUE: begin
                    state  <= WAIT;
                    to_cnt <= to_cnt + 1'b1;
                end
                WAIT: begin
                    // done on the final timeout cycle still counts as success
                    if (bus.mdio_done) begin
                        state <= IDLE;
                        if (owner == OWN_HOST) begin
                            host_done    <= 1'b1;
                            host_rd_data <= bus.mdio_rd_data;
                        end else begin
                            link_status <= bus.mdio_rd_data[15:0];
                            link_up     <= bus.mdio_rd_data[2];
                            poll_err    <= 1'b0;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state <= IDLE;
                        if (owner == OWN_HOST) begin
                            host_done <= 1'b1;
                            host_err  <= 1'b1;
                        end else begin
                            poll_err <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mdio_en      = mdio_en;
    assign bus.mdio_wr_data = mdio_wr_data;
    assign bus.host_done    = host_done;
    assign bus.host_rd_data = host_rd_data;
    assign bus.host_err     = host_err;
    assign bus.link_up      = link_up;
    assign bus.link_status  = link_status;
    assign bus.poll_err     = poll_err;

endmodule

// File: tb/tb_mdio_arb_seq.sv
// Directed-plus-random bench for mdio_arb_seq; the bench plays both the host
// and the MDIO controller and predicts results from transaction-level rules.
module tb_mdio_arb_seq;

    localparam int unsigned P = 160;
    localparam int unsigned T = 48;
    localparam logic [31:0] POLL_FRAME = 32'h6086_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mdio_arb_seq_if bus ();

    mdio_arb_seq #(
        .C_PHY_ADDR   (5'd1),
        .C_POLL_CYCLES(P),
        .C_TIMEOUT    (T)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // clock edges since reset release
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    // expected values of the sticky/held outputs
    logic [31:0] m_rd;
    logic [15:0] m_ls;
    logic        m_lu;
    logic        m_perr;
    logic        m_herr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".mdio_en"},      32'(bus.mdio_en),      32'd0);
        chk({tag, ".host_done"},    32'(bus.host_done),    32'd0);
        chk({tag, ".host_rd_data"}, bus.host_rd_data,      m_rd);
        chk({tag, ".host_err"},     32'(bus.host_err),     32'(m_herr));
        chk({tag, ".link_up"},      32'(bus.link_up),      32'(m_lu));
        chk({tag, ".link_status"},  32'(bus.link_status),  32'(m_ls));
        chk({tag, ".poll_err"},     32'(bus.poll_err),     32'(m_perr));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".mdio_en"},      32'(bus.mdio_en),     32'd0);
        chk({tag, ".mdio_wr_data"}, bus.mdio_wr_data,     32'd0);
        chk({tag, ".host_done"},    32'(bus.host_done),   32'd0);
        chk({tag, ".host_rd_data"}, bus.host_rd_data,     32'd0);
        chk({tag, ".host_err"},     32'(bus.host_err),    32'd0);
        chk({tag, ".link_up"},      32'(bus.link_up),     32'd0);
        chk({tag, ".link_status"},  32'(bus.link_status), 32'd0);
        chk({tag, ".poll_err"},     32'(bus.poll_err),    32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.host_req     = 1'b0;
        bus.host_wr_data = '0;
        bus.mdio_done    = 1'b0;
        bus.mdio_rd_data = '0;
        m_rd = '0; m_ls = '0; m_lu = 1'b0; m_perr = 1'b0; m_herr = 1'b0;
        repeat (3) tick();
        check_reset({tag, ".rst"});
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for an mdio_en pulse and checks the cycle it appeared on.
    task automatic wait_en(input string tag, input int exp_cyc, input int bound);
        int at;
        at = -1;
        for (int i = 0; i <= bound; i++) begin
            if (bus.mdio_en === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        chk({tag, ".issue_cyc"}, 32'(at), 32'(exp_cyc));
    endtask

    // Plays the MDIO controller from the ISSUE cycle to completion.
    // lat = cycles after ISSUE at which done is driven (0 = never, forces timeout).
    // glitch > 0 raises host_req briefly during WAIT to show it is not latched.
    task automatic serve(input string tag, input bit is_host, input logic [31:0] frame,
                         input int lat, input logic [31:0] rd, input int glitch);
        int last_k;
        last_k = (lat == 0) ? int'(T) : lat + 1;
        if (is_host) m_herr = 1'b0;
        chk({tag, ".wr_data"},   bus.mdio_wr_data,  frame);
        chk({tag, ".err_issue"}, 32'(bus.host_err), 32'(m_herr));
        for (int k = 1; k < last_k; k++) begin
            tick();
            chk({tag, ".en_low"},    32'(bus.mdio_en),   32'd0);
            chk({tag, ".wr_hold"},   bus.mdio_wr_data,   frame);
            chk({tag, ".done_low"},  32'(bus.host_done), 32'd0);
            if (glitch > 0 && k == glitch)     bus.host_req = 1'b1;
            if (glitch > 0 && k == glitch + 2) bus.host_req = 1'b0;
            if (k == lat) begin
                bus.mdio_done    = 1'b1;
                bus.mdio_rd_data = rd;
            end
        end
        tick();
        bus.mdio_done    = 1'b0;
        bus.mdio_rd_data = $urandom;
        if (is_host) begin
            if (lat != 0) m_rd = rd;
            else          m_herr = 1'b1;
        end else begin
            if (lat != 0) begin
                m_ls = rd[15:0];
                m_lu = rd[2];
                m_perr = 1'b0;
            end else begin
                m_perr = 1'b1;
            end
        end
        chk({tag, ".host_done"},    32'(bus.host_done),   32'(is_host));
        chk({tag, ".en_end"},       32'(bus.mdio_en),     32'd0);
        chk({tag, ".host_rd_data"}, bus.host_rd_data,     m_rd);
        chk({tag, ".host_err"},     32'(bus.host_err),    32'(m_herr));
        chk({tag, ".link_up"},      32'(bus.link_up),     32'(m_lu));
        chk({tag, ".link_status"},  32'(bus.link_status), 32'(m_ls));
        chk({tag, ".poll_err"},     32'(bus.poll_err),    32'(m_perr));
    endtask

    // Issues one host transaction from an IDLE cycle and returns to IDLE with req low.
    task automatic host_txn(input string tag, input logic [31:0] frame, input int lat,
                            input logic [31:0] rd);
        int c0;
        c0 = cyc;
        bus.host_wr_data = frame;
        bus.host_req     = 1'b1;
        tick();
        wait_en(tag, c0 + 1, 2);
        bus.host_wr_data = ~frame;
        serve(tag, 1'b1, frame, lat, rd, 0);
        bus.host_req = 1'b0;
        tick();
        check_idle({tag, ".after"});
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] hf;
        bit          poll_served;
        bit          finished;

        // ---- host only, then random host transactions ----
        do_reset("s1");
        check_reset("s1.release");
        host_txn("s1.h0", 32'h5806_0000, 40, 32'h0000_1234);
        chk("s1.rd_1234", bus.host_rd_data, 32'h0000_1234);
        for (int n = 0; n < 3; n++)
            host_txn("s1.hr", $urandom, int'($urandom_range(1, 20)), $urandom);

        // ---- spurious done, timeout, sticky error, boundary done ----
        do_reset("s4");
        host_txn("s4.h1", $urandom, int'($urandom_range(1, 10)), $urandom);
        bus.mdio_done    = 1'b1;
        bus.mdio_rd_data = $urandom;
        tick();
        bus.mdio_done = 1'b0;
        check_idle("s4.spurious1");
        tick();
        check_idle("s4.spurious2");
        host_txn("s4.tmo", $urandom, 0, $urandom);
        chk("s4.err_sticky", 32'(bus.host_err), 32'd1);
        host_txn("s4.edge", $urandom, int'(T) - 1, $urandom);
        chk("s4.err_cleared", 32'(bus.host_err), 32'd0);

        // ---- contention: host held, poll must interleave ----
        do_reset("s3");
        poll_served = 1'b0;
        finished    = 1'b0;
        hf = $urandom;
        bus.host_wr_data = hf;
        bus.host_req     = 1'b1;
        for (int it = 0; it < 100 && !finished; it++) begin
            int c;
            c = cyc;
            if (!poll_served && c >= int'(P)) begin
                tick();
                wait_en("s3.poll", c + 1, 1);
                rd = $urandom;
                serve("s3.poll", 1'b0, POLL_FRAME, int'($urandom_range(1, 30)), rd, 0);
                poll_served = 1'b1;
            end else begin
                tick();
                wait_en("s3.host", c + 1, 1);
                serve("s3.host", 1'b1, hf, int'($urandom_range(1, 20)), $urandom, 0);
                if (poll_served) begin
                    finished = 1'b1;
                end else begin
                    hf = $urandom;
                    bus.host_wr_data = hf;
                end
            end
        end
        chk("s3.order_done", 32'(finished), 32'd1);
        bus.host_req = 1'b0;
        tick();
        check_idle("s3.after");

        // ---- poll only: success, random, timeout, recovery ----
        do_reset("s2");
        wait_en("s2.p1", int'(P) + 1, int'(P) + 5);
        rd = {16'($urandom), 16'h786D};
        serve("s2.p1", 1'b0, POLL_FRAME, int'($urandom_range(6, T - 1)), rd, 2);
        chk("s2.ls_786d", 32'(bus.link_status), 32'h0000_786D);
        chk("s2.link_up", 32'(bus.link_up), 32'd1);
        tick();
        check_idle("s2.no_host");
        wait_en("s2.p2", 2 * int'(P) + 1, 2 * int'(P));
        serve("s2.p2", 1'b0, POLL_FRAME, int'($urandom_range(1, T - 1)), $urandom, 0);
        wait_en("s2.p3", 3 * int'(P) + 1, 2 * int'(P));
        serve("s2.p3", 1'b0, POLL_FRAME, 0, $urandom, 0);
        chk("s2.perr_set", 32'(bus.poll_err), 32'd1);
        wait_en("s2.p4", 4 * int'(P) + 1, 2 * int'(P));
        rd = $urandom;
        rd[2] = ~m_lu;
        serve("s2.p4", 1'b0, POLL_FRAME, int'($urandom_range(1, T - 1)), rd, 0);
        chk("s2.perr_clr", 32'(bus.poll_err), 32'd0);

        // ---- reset while waiting, then a late done ----
        do_reset("s6");
        bus.host_wr_data = $urandom;
        bus.host_req     = 1'b1;
        tick();
        wait_en("s6.h", 1, 2);
        repeat (5) begin
            tick();
            chk("s6.en_low", 32'(bus.mdio_en), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        check_reset("s6.async");
        bus.host_req = 1'b0;
        repeat (3) tick();
        check_reset("s6.held");
        rst_n = 1'b1;
        bus.mdio_done    = 1'b1;
        bus.mdio_rd_data = $urandom;
        tick();
        bus.mdio_done = 1'b0;
        repeat (5) begin
            check_reset("s6.post");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
